// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: data widths and the read-downsizer state encoding.
package fifo_pkg;

    localparam int FIFO_DW  = 128;
    localparam int DS_OUT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } ds_state_t;

endpackage

// File: rtl/fifo_rd_downsizer.sv
// Drains full FIFO words and serialises each into IN_W/OUT_W narrow beats, LSB slice first.
// Optional FIFO_RD_DS_CNT_EN adds o_word_cnt, a wrapping count of completed words.
import fifo_pkg::*;

module fifo_rd_downsizer #(
    parameter int IN_W  = FIFO_DW,
    parameter int OUT_W = DS_OUT_W
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             o_rden,
    input  logic [IN_W-1:0]  i_rddata,
    input  logic             i_empty,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_last,
    output logic             o_busy
`ifdef FIFO_RD_DS_CNT_EN
   ,output logic [31:0]      o_word_cnt
`endif
);

    localparam int RATIO  = IN_W / OUT_W;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    ds_state_t         state_q, state_d;
    logic [BEAT_W-1:0] beat_q;
    logic [IN_W-1:0]   hold_q;
    logic              xfer;
    logic              last_xfer;

    assign xfer      = (state_q == SEND) && i_ready;
    assign last_xfer = xfer && (beat_q == LAST_BEAT);

    // The next read may only be issued from IDLE or on the last-beat transfer,
    // which keeps at most one read in flight and costs one bubble per word.
    always_comb begin
        state_d = state_q;
        o_rden  = 1'b0;
        case (state_q)
            IDLE: begin
                o_rden = !i_empty;
                if (!i_empty) state_d = LOAD;
            end
            LOAD: state_d = SEND;
            SEND: begin
                if (last_xfer) begin
                    o_rden  = !i_empty;
                    state_d = i_empty ? IDLE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                hold_q <= i_rddata;
                beat_q <= '0;
            end else if (xfer && !last_xfer) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign o_valid = (state_q == SEND);
    assign o_last  = o_valid && (beat_q == LAST_BEAT);
    assign o_busy  = (state_q != IDLE);
    assign o_data  = o_valid ? hold_q[beat_q*OUT_W +: OUT_W] : '0;

`ifdef FIFO_RD_DS_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          o_word_cnt <= '0;
        else if (last_xfer) o_word_cnt <= o_word_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// Randomised bench for fifo_rd_downsizer with a queue-based FIFO and beat scoreboard.
module tb_fifo_rd_downsizer;

    localparam int IN_W  = 128;
    localparam int OUT_W = 32;
    localparam int RATIO = IN_W / OUT_W;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    logic             clk;
    logic             rstn;
    logic             o_rden;
    logic [IN_W-1:0]  i_rddata;
    logic             i_empty;
    logic             o_valid;
    logic             i_ready;
    logic [OUT_W-1:0] o_data;
    logic             o_last;
    logic             o_busy;
`ifdef FIFO_RD_DS_CNT_EN
    logic [31:0]      o_word_cnt;
`endif

    fifo_rd_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .o_rden   (o_rden),
        .i_rddata (i_rddata),
        .i_empty  (i_empty),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_busy   (o_busy)
`ifdef FIFO_RD_DS_CNT_EN
       ,.o_word_cnt (o_word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [IN_W-1:0] fq[$];
    beat_t           exp_q[$];
    int              cyc = 0;
    int              rden_cnt = 0;
    int              last_xfer_cyc = 0;
    int              words_done = 0;

    // Synchronous FIFO: data appears one cycle after a sampled read strobe.
    always @(posedge clk) begin
        cyc++;
        if (rstn && o_rden) begin
            if (fq.size() == 0) begin
                chk("underflow", 1, 0);
            end else begin
                logic [IN_W-1:0] w;
                w = fq.pop_front();
                i_rddata <= w;
                for (int i = 0; i < RATIO; i++) begin
                    beat_t b;
                    b.data = OUT_W'(w >> (OUT_W * i));
                    b.last = (i == RATIO - 1);
                    exp_q.push_back(b);
                end
            end
        end
        #1 i_empty = (fq.size() == 0);
    end

    // Scoreboard and handshake monitor, sampled mid-cycle.
    logic             stall_q = 1'b0;
    logic [OUT_W-1:0] stall_data;
    always @(negedge clk) begin
        if (rstn) begin
            if (o_rden) begin
                rden_cnt++;
                chk("rden_while_empty", i_empty, 0);
            end
            if (stall_q) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_data", o_data, stall_data);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", o_data, e.data);
                    chk("beat_last", o_last, e.last);
                    if (e.last) begin
                        words_done++;
                        last_xfer_cyc = cyc;
                    end
                end
            end
            stall_q    = o_valid && !i_ready;
            stall_data = o_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [IN_W-1:0] w);
        fq.push_back(w);
        i_empty = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((o_busy || fq.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk(tag, (n < budget), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_last"},  o_last,  0);
        chk({tag, "_busy"},  o_busy,  0);
        chk({tag, "_data"},  o_data,  0);
        chk({tag, "_rden"},  o_rden,  0);
    endtask

    localparam logic [127:0] WORD_ABCD = 128'h0000000D_0000000C_0000000B_0000000A;

    initial begin
        int t0, n, r0;
        rstn = 1'b0; i_ready = 1'b0; i_empty = 1'b1; i_rddata = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) step();
        rstn = 1'b1;
        step();

        // 1: single word, full rate
        i_ready = 1'b1;
        r0 = rden_cnt;
        push_word(WORD_ABCD);
        n = 0;
        @(negedge clk);
        while (!o_rden && n < 10) begin @(negedge clk); n++; end
        chk("t1_rden_seen", o_rden, 1);
        t0 = cyc;
        n = 0;
        while (!o_valid && n < 10) begin @(negedge clk); n++; end
        chk("t1_first_latency", cyc - t0, 2);
        chk("t1_first_data", o_data, 32'hA);
        wait_idle("t1_drain", 20);
        chk("t1_rden_pulses", rden_cnt - r0, 1);
        chk("t1_busy_end", o_busy, 0);

        // 2: backpressure on beat B
        push_word(WORD_ABCD);
        n = 0;
        @(negedge clk);
        while (!(o_valid && o_data == 32'hA) && n < 10) begin @(negedge clk); n++; end
        chk("t2_saw_a", o_data, 32'hA);
        step();
        i_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t2_hold_valid", o_valid, 1);
            chk("t2_hold_data", o_data, 32'hB);
        end
        step();
        i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_next_c", o_data, 32'hC);
        wait_idle("t2_drain", 20);

        // 3: four words back-to-back
        r0 = rden_cnt;
        for (int i = 0; i < 4; i++) fq.push_back({4{32'(i + 1) << 8}} ^ WORD_ABCD);
        i_empty = 1'b0;
        n = 0;
        @(negedge clk);
        while (!o_rden && n < 10) begin @(negedge clk); n++; end
        t0 = cyc;
        wait_idle("t3_drain", 40);
        chk("t3_rden_pulses", rden_cnt - r0, 4);
        chk("t3_span", last_xfer_cyc - t0, 4 * (RATIO + 1));

        // 4: empty hold-off
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("t4_idle", {o_rden, o_valid, o_busy}, 3'b000);
        end

        // 5: reset after beat B transfers
        push_word(WORD_ABCD);
        n = 0;
        @(negedge clk);
        while (!(o_valid && o_data == 32'hC) && n < 20) begin @(negedge clk); n++; end
        chk("t5_saw_c", o_data, 32'hC);
        #1 rstn = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        exp_q.delete();
        words_done = 0;
        step();
        step();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_no_rden", o_rden, 0);
        end
        step();
        push_word(128'h00000044_00000033_00000022_00000011);
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 10) begin @(negedge clk); n++; end
        chk("t5_restart_beat0", o_data, 32'h11);
        wait_idle("t5_drain", 20);

        // random traffic with random backpressure
        for (int i = 0; i < 800; i++) begin
            step();
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0 && fq.size() < 4)
                push_word({$urandom, $urandom, $urandom, $urandom});
        end
        step();
        i_ready = 1'b1;
        wait_idle("rand_drain", 200);

`ifdef FIFO_RD_DS_CNT_EN
        // 6: word counter
        @(negedge clk);
        chk("cnt_running", o_word_cnt, 32'(words_done));
        rstn = 1'b0;
        #1;
        chk("cnt_reset", o_word_cnt, 0);
        words_done = 0;
        step();
        rstn = 1'b1;
        step();
        for (int i = 0; i < 3; i++) push_word(WORD_ABCD);
        wait_idle("cnt_drain", 40);
        @(negedge clk);
        chk("cnt_three", o_word_cnt, 3);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
